// File: rtl/mode_sequencer.sv
// Run-mode controller: qualifies a stable mode request, drains the outgoing engine, then enables
// the new one. Define DRAIN_TIMEOUT_EN to bound the drain wait and report a sticky timeout_err.
module mode_sequencer #(
  parameter int unsigned NUM_MODES     = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DRAIN_TIMEOUT = 255,
  localparam int unsigned SEL_W = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NUM_MODES-1:0] engine_idle,
  output logic [SEL_W-1:0]     active,
  output logic [NUM_MODES-1:0] active_oh,
  output logic                 switching,
  output logic                 mode_changed,
  output logic                 timeout_err
);

  localparam int unsigned CNT_W = ($clog2(STABLE_CYCLES + 1) > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [NUM_MODES-1:0] OneHot0 = NUM_MODES'(1);

  typedef enum logic [1:0] {StRun, StQual, StDrain} state_e;

  state_e               r_state, w_state;
  logic [SEL_W-1:0]     r_cand, w_cand;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [SEL_W-1:0]     r_active, w_active;
  logic [NUM_MODES-1:0] r_active_oh, w_active_oh;
  logic                 r_switching, w_switching;
  logic                 r_mode_changed, w_mode_changed;

  logic                 w_sel_valid;
  logic                 w_idle;
  logic                 w_commit;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [NUM_MODES-1:0] w_cand_oh;

  assign w_sel_valid = (32'(sel) < NUM_MODES);
  assign w_idle      = engine_idle[r_active];
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_cand_oh   = OneHot0 << r_cand;

`ifdef DRAIN_TIMEOUT_EN
  localparam int unsigned DCNT_W = ($clog2(DRAIN_TIMEOUT + 1) > 1) ? $clog2(DRAIN_TIMEOUT + 1) : 1;

  logic [DCNT_W-1:0] r_dcnt, w_dcnt;
  logic              r_timeout_err, w_timeout_err;
  logic              w_timeout_hit;

  // r_dcnt counts DRAIN cycles already spent, so the limit is hit on the last allowed cycle
  assign w_timeout_hit = (32'(r_dcnt) == DRAIN_TIMEOUT - 1);
  assign w_commit      = (r_state == StDrain) && (w_idle || w_timeout_hit);

  always_comb begin
    w_dcnt        = r_dcnt;
    w_timeout_err = r_timeout_err;
    if (r_state != StDrain) begin
      w_dcnt = '0;
    end else if (!w_commit) begin
      w_dcnt = r_dcnt + DCNT_W'(1);
    end
    // A same-edge idle wins over the timeout
    if (w_commit && !w_idle) begin
      w_timeout_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dcnt        <= w_dcnt;
      r_timeout_err <= w_timeout_err;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^(32'(DRAIN_TIMEOUT));
  assign w_commit         = (r_state == StDrain) && w_idle;
  assign timeout_err      = 1'b0;
`endif

  always_comb begin
    w_state        = r_state;
    w_cand         = r_cand;
    w_cnt          = r_cnt;
    w_active       = r_active;
    w_active_oh    = r_active_oh;
    w_mode_changed = 1'b0;

    unique case (r_state)
      StRun: begin
        if (w_sel_valid && (sel != r_active)) begin
          w_cand  = sel;
          w_cnt   = CNT_W'(1);
          w_state = (STABLE_CYCLES == 1) ? StDrain : StQual;
        end
      end
      StQual: begin
        if (sel == r_cand) begin
          w_cnt = w_cnt_inc;
          if (32'(w_cnt_inc) == STABLE_CYCLES) begin
            w_state = StDrain;
          end
        end else if (sel == r_active) begin
          w_state = StRun;
        end else if (w_sel_valid) begin
          w_cand = sel;
          w_cnt  = CNT_W'(1);
        end else begin
          w_state = StRun;
        end
      end
      StDrain: begin
        // sel is deliberately ignored here; the candidate is already committed
        if (w_commit) begin
          w_state        = StRun;
          w_active       = r_cand;
          w_active_oh    = w_cand_oh;
          w_mode_changed = 1'b1;
        end
      end
      default: begin
        w_state = StRun;
      end
    endcase

    if ((w_state == StDrain) && (r_state != StDrain)) begin
      w_active_oh = '0;
    end
    w_switching = (w_state != StRun);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= StRun;
      r_cand         <= '0;
      r_cnt          <= '0;
      r_active       <= '0;
      r_active_oh    <= OneHot0;
      r_switching    <= 1'b0;
      r_mode_changed <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_cand         <= w_cand;
      r_cnt          <= w_cnt;
      r_active       <= w_active;
      r_active_oh    <= w_active_oh;
      r_switching    <= w_switching;
      r_mode_changed <= w_mode_changed;
    end
  end

  assign active       = r_active;
  assign active_oh    = r_active_oh;
  assign switching    = r_switching;
  assign mode_changed = r_mode_changed;

endmodule

// File: tb/tb_mode_sequencer.sv
// Scoreboard bench for mode_sequencer: a request-history reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_mode_sequencer;

  localparam int unsigned NM = 5;
  localparam int unsigned SC = 3;
  localparam int unsigned DT = 8;
  localparam int unsigned SW = 3;
`ifdef DRAIN_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sel;
  logic [NM-1:0] engine_idle;
  logic [SW-1:0] active;
  logic [NM-1:0] active_oh;
  logic          switching;
  logic          mode_changed;
  logic          timeout_err;

  mode_sequencer #(
    .NUM_MODES    (NM),
    .STABLE_CYCLES(SC),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .engine_idle (engine_idle),
    .active      (active),
    .active_oh   (active_oh),
    .switching   (switching),
    .mode_changed(mode_changed),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] active;
    logic [NM-1:0] oh;
    logic          sw;
    logic          mc;
    logic          te;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a mode switch is due once the last SC samples taken outside a drain all
  // name the same valid mode that differs from the current one.
  int m_active;
  int m_cand;
  bit m_drain;
  int m_dcyc;
  bit m_err;
  int hist[$];

  function automatic void model_reset();
    m_active = 0;
    m_cand   = 0;
    m_drain  = 1'b0;
    m_dcyc   = 0;
    m_err    = 1'b0;
    hist.delete();
  endfunction

  function automatic exp_t model_edge(input int s, input logic [NM-1:0] idle);
    exp_t          e;
    bit            mc;
    bit            pending;
    int            run;
    logic [NM-1:0] one;
    one = 1;
    mc  = 1'b0;
    if (m_drain) begin
      m_dcyc++;
      if (idle[m_active] || (TMO && (m_dcyc == DT))) begin
        if (!idle[m_active]) m_err = 1'b1;
        m_active = m_cand;
        m_drain  = 1'b0;
        mc       = 1'b1;
        hist.delete();
      end
    end else begin
      hist.push_back(s);
      while (hist.size() > SC) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != s) break;
        run++;
      end
      if ((s < NM) && (s != m_active) && (run >= SC)) begin
        m_drain = 1'b1;
        m_cand  = s;
        m_dcyc  = 0;
        hist.delete();
      end
    end
    pending  = !m_drain && (hist.size() > 0) && (hist[$] < NM) && (hist[$] != m_active);
    e.active = SW'(m_active);
    e.oh     = m_drain ? '0 : (one << m_active);
    e.sw     = m_drain || pending;
    e.mc     = mc;
    e.te     = TMO ? m_err : 1'b0;
    return e;
  endfunction

  // Called in the negedge region; returns in the next negedge region.
  task automatic step(input int s, input logic [NM-1:0] idle);
    exp_t e;
    sel         = SW'(s);
    engine_idle = idle;
    @(posedge clk);
    e = model_edge(s, idle);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_active_oh"}, 32'(active_oh), 32'd1);
    chk({tag, "_switching"}, 32'(switching), 32'd0);
    chk({tag, "_mode_changed"}, 32'(mode_changed), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("active", 32'(active), 32'(e.active));
      chk("active_oh", 32'(active_oh), 32'(e.oh));
      chk("switching", 32'(switching), 32'(e.sw));
      chk("mode_changed", 32'(mode_changed), 32'(e.mc));
      chk("timeout_err", 32'(timeout_err), 32'(e.te));
    end
  end

  logic [NM-1:0] all_idle;
  logic [NM-1:0] busy2;

  initial begin
    int s;
    int len;
    int n;
    logic [NM-1:0] idle;
    all_idle    = '1;
    busy2       = 5'b11011;
    reset       = 1'b1;
    sel         = '0;
    engine_idle = '1;
    model_reset();
    #1;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) step(0, all_idle);
    for (int i = 0; i < 8; i++) step(2, all_idle);
    for (int i = 0; i < 2; i++) step(3, all_idle);
    for (int i = 0; i < 6; i++) step(2, all_idle);
    // Request mode 1 while engine 2 stays busy; move sel to 3 mid-drain
    for (int i = 0; i < 6; i++) step(1, busy2);
    for (int i = 0; i < 8; i++) step(3, busy2);
    for (int i = 0; i < 2; i++) step(3, all_idle);
    for (int i = 0; i < 8; i++) step(1, all_idle);
    for (int v = 5; v < 8; v++) begin
      for (int i = 0; i < 4; i++) step(v, all_idle);
    end

    for (int seg = 0; seg < 400; seg++) begin
      s   = ($urandom_range(0, 9) < 2) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        idle = ($urandom_range(0, 3) == 0) ? NM'($urandom) : NM'($urandom | $urandom);
        step(s, idle);
      end
    end

    // Async reset in the middle of a drain
    n = 0;
    while (!(m_drain && (m_dcyc >= 1)) && (n < 50)) begin
      step((m_active + 1) % NM, '0);
      n++;
    end
    chk("reach_drain", 32'(m_drain), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int seg = 0; seg < 100; seg++) begin
      s   = ($urandom_range(0, 9) < 2) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) step(s, NM'($urandom | $urandom));
    end

    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
